// File: rtl/curve25519_pkg.sv
// -----------------------------------------------------------------------------
// curve25519_pkg
// Shared constants and types for the Curve25519 field datapath.
//   DATA_W    : field element width in bits
//   FOLD_C    : 2^255 mod p, used to fold high bits back into the low word
//   P_25519   : the prime p = 2^255 - 19
//   P_MINUS_2 : Fermat inversion exponent p - 2 = 2^255 - 21
//   state_t   : proj_to_affine controller states
// -----------------------------------------------------------------------------
package curve25519_pkg;

  localparam int DATA_W = 255;
  localparam int FOLD_C = 19;

  localparam logic [DATA_W-1:0] P_25519   = {{(DATA_W-5){1'b1}}, 5'b01101};
  localparam logic [DATA_W-1:0] P_MINUS_2 = {{(DATA_W-5){1'b1}}, 5'b01011};

  // Bit 254 of the exponent is consumed by initialising acc = Z, so the
  // square-and-multiply walk starts one bit lower.
  localparam logic [7:0] EXP_START_BIT = 8'd253;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SQR   = 3'd1,
    S_MUL   = 3'd2,
    S_FIN_X = 3'd3,
    S_FIN_Y = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/mod_mul_25519.sv
// -----------------------------------------------------------------------------
// mod_mul_25519
// Interleaved MSB-first digit-serial modular multiplier, p = 2^255 - 19.
// Each cycle: acc = (acc * 2^MUL_DIGIT + a_digit * b) mod p.
// Latency from i_start to o_done is ceil(DATA_W / MUL_DIGIT) + 1 cycles.
// Operands may be anything in [0, 2^DATA_W); o_p is always fully reduced.
// A new i_start is accepted in any cycle, including the o_done cycle.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_start : latch i_a / i_b and begin a multiply
//   i_a     : multiplicand scanned digit by digit, MSB first
//   i_b     : multiplicand applied whole each cycle
//   o_p     : product a*b mod p, valid while o_done is high
//   o_done  : one-cycle pulse when o_p is ready
// -----------------------------------------------------------------------------
module mod_mul_25519 #(
  parameter int DATA_W    = curve25519_pkg::DATA_W,
  parameter int MUL_DIGIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_p,
  output logic              o_done
);
  import curve25519_pkg::*;

  localparam int N_DIG = (DATA_W + MUL_DIGIT - 1) / MUL_DIGIT;
  localparam int PAD_W = N_DIG * MUL_DIGIT;
  localparam int SUM_W = DATA_W + MUL_DIGIT + 1;
  localparam int CNT_W = $clog2(N_DIG + 1);

  logic [PAD_W-1:0]     a_sh;
  logic [DATA_W-1:0]    b_q;
  logic [DATA_W-1:0]    acc;
  logic [CNT_W-1:0]     cnt;
  logic                 busy;

  logic [MUL_DIGIT-1:0] digit;
  logic [SUM_W-1:0]     prod;
  logic [SUM_W-1:0]     sum;
  logic [DATA_W:0]      folded;
  logic [DATA_W-1:0]    diff;
  logic [DATA_W-1:0]    acc_nxt;

  // acc < p and a_digit*b < 2^(DATA_W+MUL_DIGIT), so one fold of the bits
  // above 2^255 (times 19) leaves a value below 2p as long as MUL_DIGIT is
  // small against DATA_W; a single conditional subtract then fully reduces.
  always_comb begin
    digit  = a_sh[PAD_W-1 -: MUL_DIGIT];
    prod   = {{(SUM_W-MUL_DIGIT){1'b0}}, digit} * {{(SUM_W-DATA_W){1'b0}}, b_q};
    sum    = ({{(MUL_DIGIT+1){1'b0}}, acc} << MUL_DIGIT) + prod;
    folded = {1'b0, sum[DATA_W-1:0]}
           + {{(DATA_W-MUL_DIGIT){1'b0}}, sum[SUM_W-1:DATA_W]} * (DATA_W+1)'(FOLD_C);
    // When folded >= p the true difference is < 2^255, so the low word suffices.
    diff    = folded[DATA_W-1:0] - P_25519;
    acc_nxt = (folded < {1'b0, P_25519}) ? folded[DATA_W-1:0] : diff;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_sh   <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        a_sh <= PAD_W'(i_a);
        b_q  <= i_b;
        acc  <= '0;
        cnt  <= CNT_W'(N_DIG);
        busy <= 1'b1;
      end else if (busy) begin
        acc  <= acc_nxt;
        a_sh <= a_sh << MUL_DIGIT;
        cnt  <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy   <= 1'b0;
          o_done <= 1'b1;
        end
      end
    end
  end

  assign o_p = acc;

endmodule

// File: rtl/proj_to_affine.sv
// -----------------------------------------------------------------------------
// proj_to_affine
// Converts projective twisted-Edwards (X, Y, Z) to affine (x, y) over
// p = 2^255 - 19: Z^-1 = Z^(p-2) by left-to-right square-and-multiply on one
// shared mod_mul_25519, then x = X*Z^-1 and y = Y*Z^-1. Multiplies are issued
// back to back: the next one starts in the cycle the previous reports done.
// Optional build macro PROJ_TO_AFFINE_ZERO_Z_CHECK_EN: Z == 0 or Z == p skips
// the inversion, returns 0/0 two cycles after acceptance and pulses o_invalid.
//   i_clk      : clock
//   i_rst      : synchronous active-high reset (aborts any operation)
//   i_start    : start pulse, accepted only when idle
//   i_x/i_y/i_z: projective coordinates, any value in [0, 2^255)
//   o_x/o_y    : affine result, fully reduced, updated only with o_finished
//   o_busy     : high from acceptance through the o_finished cycle
//   o_finished : one-cycle pulse when o_x/o_y are loaded
//   o_invalid  : (macro only) pulses with o_finished when Z was 0 mod p
// -----------------------------------------------------------------------------
module proj_to_affine #(
  parameter int DATA_W    = curve25519_pkg::DATA_W,
  parameter int MUL_DIGIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_y,
  input  logic [DATA_W-1:0] i_z,
  output logic [DATA_W-1:0] o_x,
  output logic [DATA_W-1:0] o_y,
  output logic              o_busy,
`ifdef PROJ_TO_AFFINE_ZERO_Z_CHECK_EN
  output logic              o_invalid,
`endif
  output logic              o_finished
);
  import curve25519_pkg::*;

  state_t            state;
  logic [DATA_W-1:0] x_q, y_q, z_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] x_res;
  logic [7:0]        bit_cnt;
  logic              kick_q;

  logic              mul_start;
  logic [DATA_W-1:0] mul_a, mul_b;
  logic [DATA_W-1:0] mul_p;
  logic              mul_done;
  logic              e_bit;

`ifdef PROJ_TO_AFFINE_ZERO_Z_CHECK_EN
  logic zero_q;
  logic z_is_zero;
  assign z_is_zero = (i_z == '0) || (i_z == P_25519);
`endif

  assign e_bit  = P_MINUS_2[bit_cnt];
  assign o_busy = (state != S_IDLE);

  mod_mul_25519 #(
    .DATA_W    (DATA_W),
    .MUL_DIGIT (MUL_DIGIT)
  ) u_mul (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (mul_start),
    .i_a     (mul_a),
    .i_b     (mul_b),
    .o_p     (mul_p),
    .o_done  (mul_done)
  );

  // Operands for the next multiply are chosen in the done cycle of the
  // current one, using the fresh product directly to avoid a bubble.
  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    mul_start = kick_q;
    mul_a     = z_q;
    mul_b     = z_q;
    if (mul_done) begin
      case (state)
        S_SQR: begin
          mul_start = 1'b1;
          if (e_bit) begin
            mul_a = mul_p;
            mul_b = z_q;
          end else if (bit_cnt == '0) begin
            mul_a = x_q;
            mul_b = mul_p;
          end else begin
            mul_a = mul_p;
            mul_b = mul_p;
          end
        end
        S_MUL: begin
          mul_start = 1'b1;
          if (bit_cnt == '0) begin
            mul_a = x_q;
            mul_b = mul_p;
          end else begin
            mul_a = mul_p;
            mul_b = mul_p;
          end
        end
        S_FIN_X: begin
          mul_start = 1'b1;
          mul_a     = y_q;
          mul_b     = acc_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      acc_q      <= '0;
      x_res      <= '0;
      bit_cnt    <= '0;
      kick_q     <= 1'b0;
      o_x        <= '0;
      o_y        <= '0;
      o_finished <= 1'b0;
`ifdef PROJ_TO_AFFINE_ZERO_Z_CHECK_EN
      zero_q     <= 1'b0;
      o_invalid  <= 1'b0;
`endif
    end else begin
      kick_q     <= 1'b0;
      o_finished <= 1'b0;
`ifdef PROJ_TO_AFFINE_ZERO_Z_CHECK_EN
      o_invalid  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (i_start) begin
            x_q     <= i_x;
            y_q     <= i_y;
            z_q     <= i_z;
            acc_q   <= i_z;
            bit_cnt <= EXP_START_BIT;
            state   <= S_SQR;
`ifdef PROJ_TO_AFFINE_ZERO_Z_CHECK_EN
            zero_q  <= z_is_zero;
            kick_q  <= !z_is_zero;
`else
            kick_q  <= 1'b1;
`endif
          end
        end
        S_SQR: begin
`ifdef PROJ_TO_AFFINE_ZERO_Z_CHECK_EN
          if (zero_q) begin
            o_x        <= '0;
            o_y        <= '0;
            o_finished <= 1'b1;
            o_invalid  <= 1'b1;
            state      <= S_DONE;
          end else
`endif
          if (mul_done) begin
            acc_q <= mul_p;
            if (e_bit)                state   <= S_MUL;
            else if (bit_cnt == '0)   state   <= S_FIN_X;
            else                      bit_cnt <= bit_cnt - 8'd1;
          end
        end
        S_MUL: begin
          if (mul_done) begin
            acc_q <= mul_p;
            if (bit_cnt == '0) begin
              state <= S_FIN_X;
            end else begin
              bit_cnt <= bit_cnt - 8'd1;
              state   <= S_SQR;
            end
          end
        end
        S_FIN_X: begin
          if (mul_done) begin
            x_res <= mul_p;
            state <= S_FIN_Y;
          end
        end
        S_FIN_Y: begin
          if (mul_done) begin
            o_x        <= x_res;
            o_y        <= mul_p;
            o_finished <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
